// File: rtl/alu_muldiv_nbit.sv
// WIDTH-bit EX-stage ALU: single-cycle logic/arith/compare/shift, plus iterative MULT/DIV into HI/LO
// (WIDTH+1 cycles, Busy while running, Done pulse). Divider built only when ALU_DIVIDER_EN is defined.
module alu_muldiv_nbit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Start,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q;
  logic [SW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               neg_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [SW-1:0] shamt;
  assign shamt = A[SW-1:0];

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      4'b0000: ALUResult = A & B;
      4'b0001: ALUResult = A | B;
      4'b0010: ALUResult = A + B;
      4'b0011: ALUResult = A ^ B;
      4'b0110: ALUResult = A - B;
      4'b1100: ALUResult = ~(A | B);
      4'b0111: ALUResult[0] = $signed(A) < $signed(B);
      4'b1001: ALUResult[0] = A < B;
      4'b0100: ALUResult = B << shamt;
      4'b0101: ALUResult = B >> shamt;
      4'b1000: ALUResult = $signed(B) >>> shamt;
      4'b1010, 4'b1011: ALUResult = lo_q;
`ifdef ALU_DIVIDER_EN
      4'b1101, 4'b1110: ALUResult = lo_q;
`endif
      default: ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

  logic             is_mul, is_div, signed_op, a_neg, b_neg, launch, last;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_mul = (ALUControl == 4'b1010) || (ALUControl == 4'b1011);
`ifdef ALU_DIVIDER_EN
  assign is_div = (ALUControl == 4'b1101) || (ALUControl == 4'b1110);
`else
  assign is_div = 1'b0;
`endif
  assign signed_op = (ALUControl == 4'b1010) || (ALUControl == 4'b1101);
  assign a_neg     = signed_op & A[WIDTH-1];
  assign b_neg     = signed_op & B[WIDTH-1];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;
  assign launch    = (state_q == IDLE) && Start && (is_mul || is_div);
  assign last      = (cnt_q == SW'(WIDTH - 1));

  // Multiply: {partial product, multiplier} shifts right one bit per iteration.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] step_next;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod     = neg_q ? -mul_next : mul_next;

`ifdef ALU_DIVIDER_EN
  logic               div_q, dvz_q, rneg_q;
  logic [WIDTH-1:0]   dend_q;
  logic [WIDTH:0]     rem_s, diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo, rem;

  // Restoring divide: {remainder, dividend/quotient} shifts left, quotient bits enter at LSB.
  assign rem_s    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff     = rem_s - {1'b0, opnd_q};
  assign div_next = diff[WIDTH] ? {rem_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
  assign quo       = div_next[WIDTH-1:0];
  assign rem       = div_next[2*WIDTH-1:WIDTH];
  assign step_next = div_q ? div_next : mul_next;

  always_comb begin
    fin_hi = prod[2*WIDTH-1:WIDTH];
    fin_lo = prod[WIDTH-1:0];
    if (div_q) begin
      if (dvz_q) begin
        fin_lo = '1;
        fin_hi = dend_q;
      end else begin
        fin_lo = neg_q  ? -quo : quo;
        fin_hi = rneg_q ? -rem : rem;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_q  <= 1'b0;
      dvz_q  <= 1'b0;
      rneg_q <= 1'b0;
      dend_q <= '0;
    end else if (launch) begin
      div_q  <= is_div;
      dvz_q  <= (B == '0);
      rneg_q <= a_neg;
      dend_q <= A;
    end
  end
`else
  assign step_next = mul_next;
  assign fin_hi    = prod[2*WIDTH-1:WIDTH];
  assign fin_lo    = prod[WIDTH-1:0];
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (launch) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            acc_q   <= is_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            opnd_q  <= is_div ? b_mag : a_mag;
            neg_q   <= a_neg ^ b_neg;
          end
        end
        RUN: begin
          acc_q <= step_next;
          cnt_q <= cnt_q + SW'(1);
          // Last iteration and sign correction land on the same edge.
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= fin_hi;
            lo_q    <= fin_lo;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule

// File: doc/alu_muldiv_nbit.md
# alu_muldiv_nbit

Parametrised successor to the datapath's 32-bit ALU: a WIDTH-bit ALU whose logic, arithmetic, compare and shift operations are single-cycle combinational. It adds iterative multi-cycle multiply and divide units that write the HI/LO registers. It sits in the EX stage. The hazard unit stalls the pipeline on `Busy` and releases it on `Done`, and MFHI/MFLO read the `HI`/`LO` ports.

## Interface
- `WIDTH`, 32, operand/result width; must be ≥ 8 and a power of two.
- `Clk`  in  1  clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `ALUControl`  in  4  operation select (see Operation).
- `A`, `B`  in  WIDTH  operands; A = rs/dividend/multiplicand, B = rt/divisor/multiplier; shift amount = `A[log2(WIDTH)-1:0]`.
- `Start`  in  1  launches the multi-cycle operation selected by `ALUControl`.
- `ALUResult`  out  WIDTH  combinational result.
- `Zero`  out  1  high when `ALUResult` == 0.
- `Busy`  out  1  multi-cycle operation in progress.
- `Done`  out  1  one-cycle pulse when `HI`/`LO` have been updated.
- `HI`, `LO`  out  WIDTH  product high/low halves; remainder/quotient.

## Operation
- Combinational codes:
  - 0000 AND, 0001 OR, 0010 ADD (wraps), 0011 XOR, 0110 SUB (wraps), 1100 NOR.
  - 0111 SLT signed, 1001 SLTU unsigned (result 1 or 0).
  - 0100 SLL, 0101 SRL, 1000 SRA of B.
- Multi-cycle codes: 1010 MULT (signed), 1011 MULTU, 1101 DIV (signed), 1110 DIVU, 1111 reserved.
  - `ALUResult` shows the `LO` register for these codes.
  - 1111 gives `ALUResult` = 0 and is ignored by `Start`.
- `ALUResult` is fully assigned for every code; no latches.
- FSM states IDLE, RUN, DONE:
  - IDLE → RUN when `Start`=1 and the code is multi-cycle. Latches operands, operation and sign flags. Signed ops convert operands to magnitudes.
  - RUN runs WIDTH iterations, one per cycle:
    - Multiply: shift-add into a 2·WIDTH accumulator.
    - Divide: restoring shift-subtract.
  - RUN → DONE after iteration WIDTH. Applies sign correction and writes `HI`/`LO`.
  - DONE → IDLE unconditionally.
- Sign rules:
  - Product is negated when operand signs differ.
  - Quotient is negated when signs differ; remainder takes the dividend's sign.
- Divide by zero (any signedness): `LO` = all ones, `HI` = dividend as presented; still takes full latency.
- Signed MIN / -1: `LO` = MIN, `HI` = 0 (natural result of the magnitude algorithm).
- `Start` while not in IDLE is ignored. Operands and `ALUControl` may change freely after the launch cycle.
- `HI`/`LO` hold their values until the next DONE.

## Timing
- Combinational ops: zero latency, no clock involvement.
- Launch edge = cycle 0.
  - `Busy`=1 in cycles 1..WIDTH.
  - `Done`=1 and `Busy`=0 in cycle WIDTH+1; new `HI`/`LO` are visible in that same cycle.
- Back-to-back: a new `Start` is accepted in the `Done` cycle's successor (IDLE), so throughput is one op per WIDTH+2 cycles.
- Reset values: FSM IDLE, `Busy`=0, `Done`=0, `HI`=0, `LO`=0, internal accumulators 0.
- Reset asserted mid-operation aborts immediately (asynchronous). No `Done` is produced and `HI`/`LO` clear to 0.

## Configuration
- `ALU_DIVIDER_EN` defined: DIV/DIVU are implemented as above.
- `ALU_DIVIDER_EN` undefined:
  - Divider datapath is removed.
  - 1101/1110 behave as 1111: `Start` is ignored, `Busy`/`Done` stay 0, `HI`/`LO` are unchanged.
  - MULT/MULTU are unaffected.

## Test plan
- WIDTH=32, ADD A=0x7FFFFFFF B=1 → `ALUResult`=0x80000000, `Zero`=0. SUB A=B=5 → 0, `Zero`=1. SLT A=0xFFFFFFFF B=0 → 1; SLTU same operands → 0. SRA A=4 B=0x80000000 → 0xF8000000.
- MULT A=0xFFFFFFFE (-2) B=3 with `Start` → `Busy` for 32 cycles, `Done` in cycle 33, `HI`=0xFFFFFFFF, `LO`=0xFFFFFFFA; MULTU A=B=0xFFFFFFFF → `HI`=0xFFFFFFFE, `LO`=0x00000001.
- DIV A=-7 B=2 → `LO`=0xFFFFFFFD (-3), `HI`=0xFFFFFFFF (-1); DIVU A=100 B=7 → `LO`=14, `HI`=2; DIV A=0x80000000 B=-1 → `LO`=0x80000000, `HI`=0.
- DIVU A=0x1234 B=0 → after 33 cycles `LO`=0xFFFFFFFF, `HI`=0x1234; with `ALU_DIVIDER_EN` undefined → no `Busy`, `HI`/`LO` unchanged.
- `Start` pulsed again in cycles 5 and 33 of a MULT → ignored, single `Done`. `Start` in cycle 34 → accepted, second `Done` in cycle 67.
- `Reset` asserted in cycle 10 of DIVU → `Busy`, `Done`, `HI`, `LO` all 0 immediately; no `Done` pulse after release.
